// File: rtl/countdown_timer.sv
// Loadable down-counting timer: one-cycle tick after N ce-qualified cycles,
// with optional auto-reload for periodic event generation.
module countdown_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             load_ok;

  assign load_ok = start && (load_val != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      tick     <= 1'b0;
      reload_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_ok) begin
            count    <= load_val;
            reload_q <= load_val;
            mode_q   <= auto_reload;
            state    <= RUN;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // A zero-length restart request aborts the run like stop does.
          if (stop || (start && !load_ok)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (load_ok) begin
            count    <= load_val;
            reload_q <= load_val;
            mode_q   <= auto_reload;
          end else if (ce) begin
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              tick <= 1'b1;
              if (mode_q) begin
                count <= reload_q;
              end else begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios then random traffic,
// each cycle's expected outputs queued by the stimulus side and checked by a monitor.
module tb_countdown_timer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, ce, start, stop, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, tick;

  countdown_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .stop(stop),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(count), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] count;
    logic         busy;
    logic         tick;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  // Reference: timer described as "remaining ce events before the next expiry".
  logic         m_running = 1'b0;
  logic [W-1:0] m_left = '0;
  logic [W-1:0] m_period = '0;
  logic         m_periodic = 1'b0;
  logic         m_tick = 1'b0;

  task automatic cyc(input bit r, input bit s, input bit p, input bit c,
                     input bit a, input logic [W-1:0] lv);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; stop = p; ce = c; auto_reload = a; load_val = lv;
    m_tick = 1'b0;
    if (r) begin
      m_running = 1'b0; m_left = '0; m_period = '0; m_periodic = 1'b0;
    end else if (!m_running) begin
      if (s && lv != 0) begin
        m_running = 1'b1; m_left = lv; m_period = lv; m_periodic = a;
      end
    end else if (p || (s && lv == 0)) begin
      m_running = 1'b0;
    end else if (s) begin
      m_left = lv; m_period = lv; m_periodic = a;
    end else if (c && m_left != 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_tick = 1'b1;
        if (m_periodic) m_left = m_period;
        else m_running = 1'b0;
      end
    end
    n_cyc++;
    e.count = m_left; e.busy = m_running; e.tick = m_tick; e.cyc = n_cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit c);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, c, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (count !== e.count || busy !== e.busy || tick !== e.tick) begin
          n_bad++;
          $display("FAIL outputs cyc%0d: count=%h busy=%b tick=%b, expected count=%h busy=%b tick=%b",
                   e.cyc, count, busy, tick, e.count, e.busy, e.tick);
        end
      end
    end
  end

  initial begin : stim
    int unsigned r;
    logic [W-1:0] lv;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ce = 1'b0; auto_reload = 1'b0; load_val = '0;

    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 1, 0, '0);

    // One-shot N=5 with ce held high, then a quiet stretch.
    cyc(0, 1, 0, 1, 0, 16'd5);
    idle(25, 1);

    // Periodic N=3 with ce every 4th cycle, then stop.
    cyc(0, 1, 0, 0, 1, 16'd3);
    for (int i = 0; i < 48; i++) cyc(0, 0, 0, (i % 4) == 3, 0, '0);
    idle(2, 1);
    cyc(0, 0, 1, 1, 0, '0);
    idle(5, 1);

    // Zero-length start is ignored in IDLE.
    cyc(0, 1, 0, 1, 1, '0);
    idle(3, 1);

    // N=1 periodic ticks every cycle.
    cyc(0, 1, 0, 1, 1, 16'd1);
    idle(6, 1);
    cyc(0, 0, 1, 1, 0, '0);

    // Full-scale one-shot: first decrement to FFFE, expiry at 0 without wrap.
    cyc(0, 1, 0, 1, 0, 16'hFFFF);
    idle(65540, 1);

    // stop and start together while running.
    cyc(0, 1, 0, 1, 0, 16'd5);
    idle(2, 1);
    cyc(0, 1, 1, 1, 0, 16'd7);
    idle(3, 1);

    // stop on the terminal cycle.
    cyc(0, 1, 0, 1, 0, 16'd3);
    idle(2, 1);
    cyc(0, 0, 1, 1, 0, '0);
    idle(3, 1);

    // start on the terminal cycle restarts at 7.
    cyc(0, 1, 0, 1, 0, 16'd3);
    idle(2, 1);
    cyc(0, 1, 0, 1, 0, 16'd7);
    idle(10, 1);

    // Reset mid-run, then a normal start.
    cyc(0, 1, 0, 1, 0, 16'd5);
    idle(2, 1);
    cyc(1, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 1, 0, '0);
    cyc(0, 1, 0, 1, 0, 16'd4);
    idle(6, 1);

    // Random regression.
    for (int i = 0; i < 10000; i++) begin
      r  = $urandom;
      lv = (r[20:18] == 3'd0) ? W'($urandom) : W'($urandom_range(0, 6));
      cyc(r[9:0] == 10'd0, r[3:0] == 4'd0, r[8:4] == 5'd0, r[10], r[11], lv);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
